// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: command sequencer for a single-port RAM with a one-cycle registered read
// Ports:
//   clk_i                      clock, all logic on posedge
//   reset_ni                   synchronous active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake
//   cmd_write_i                1 = write, 0 = read
//   cmd_addr_i / cmd_wdata_i   target word / write data
//   rsp_valid_o / rsp_ready_i  read response handshake
//   rsp_data_o                 read data
//   ram_we_o / ram_addr_o / ram_wdata_o / ram_rdata_i   RAM pins
//   wr_count_o / rd_count_o    saturating completed-write / delivered-read counters
module ram_access_ctrl #(
  parameter int Data_width            = 8,
  parameter int memory_addressibility = 4,
  parameter int address_Width         = $clog2(memory_addressibility),
  parameter int CNT_W                 = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_write_i,
  input  logic [address_Width-1:0] cmd_addr_i,
  input  logic [Data_width-1:0]    cmd_wdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [Data_width-1:0]    rsp_data_o,
  output logic                     ram_we_o,
  output logic [address_Width-1:0] ram_addr_o,
  output logic [Data_width-1:0]    ram_wdata_o,
  input  logic [Data_width-1:0]    ram_rdata_i,
  output logic [CNT_W-1:0]         wr_count_o,
  output logic [CNT_W-1:0]         rd_count_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t                   state_q, state_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [Data_width-1:0]    rsp_data_q, rsp_data_d;
  logic                     ram_we_q, ram_we_d;
  logic [address_Width-1:0] ram_addr_q, ram_addr_d;
  logic [Data_width-1:0]    ram_wdata_q, ram_wdata_d;
  logic [CNT_W-1:0]         wr_count_q, wr_count_d;
  logic [CNT_W-1:0]         rd_count_q, rd_count_d;
  logic                     accept, rsp_hs, wr_done;
  assign accept  = cmd_valid_i && cmd_ready_q;
  assign rsp_hs  = rsp_valid_q && rsp_ready_i;
  // the RAM commits the write on the edge that ends ISSUE
  assign wr_done = (state_q == ISSUE) && ram_we_q;
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? ISSUE : IDLE;
      ISSUE:   state_d = ram_we_q ? IDLE : CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    state_d = rsp_hs ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    // ready is registered, so it is computed from where the FSM is going
    cmd_ready_d = (state_d == IDLE);
    ram_we_d    = accept && cmd_write_i;
    ram_addr_d  = accept ? cmd_addr_i : ram_addr_q;
    ram_wdata_d = accept ? cmd_wdata_i : ram_wdata_q;
    rsp_data_d  = (state_q == CAPTURE) ? ram_rdata_i : rsp_data_q;
    rsp_valid_d = (state_q == CAPTURE) ? 1'b1 : (rsp_hs ? 1'b0 : rsp_valid_q);
    wr_count_d  = (wr_done && wr_count_q != '1) ? wr_count_q + CNT_W'(1) : wr_count_q;
    rd_count_d  = (rsp_hs && rd_count_q != '1) ? rd_count_q + CNT_W'(1) : rd_count_q;
  end
  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign wr_count_o  = wr_count_q;
  assign rd_count_o  = rd_count_q;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed and randomised checks of ram_access_ctrl against a registered-read RAM
module tb_ram_access_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [1:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cmd_ready_o, rsp_valid_o, ram_we_o;
  logic [7:0] rsp_data_o, ram_wdata_o, ram_rdata, wr_count_o, rd_count_o;
  logic [1:0] ram_addr_o;
  logic       ram_clr = 1'b1;
  logic [7:0] ram_mem [4];
  logic [7:0] shadow [4];
  int         n_cmp = 0, n_err = 0, exp_wr = 0, exp_rd = 0;

  ram_access_ctrl dut (
    .clk_i(clk), .reset_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data_o),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata), .wr_count_o(wr_count_o), .rd_count_o(rd_count_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int k = 0; k < 4; k++) ram_mem[k] <= 8'h5A;
    end else if (ram_we_o) begin
      ram_mem[ram_addr_o] <= ram_wdata_o;
    end
    ram_rdata <= ram_mem[ram_addr_o];
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_cmd(input logic w, input logic [1:0] a, input logic [7:0] d);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = cmd_ready_o;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL cmd_accept got no accept exp accept within 20 cycles"); end
  endtask

  task automatic get_rsp(output logic [7:0] d);
    bit ok = 0;
    d = 8'hxx;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rsp_valid_o) begin ok = 1; d = rsp_data_o; end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rsp_wait got no rsp_valid exp response within 20 cycles"); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (cmd_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid_o); end
    n_cmp++; if (rsp_data_o !== 8'h00) begin n_err++; $display("FAIL rst_rsp_data got %h exp 00", rsp_data_o); end
    n_cmp++; if (ram_we_o !== 1'b0) begin n_err++; $display("FAIL rst_ram_we got %b exp 0", ram_we_o); end
    n_cmp++; if (ram_addr_o !== 2'd0) begin n_err++; $display("FAIL rst_ram_addr got %h exp 0", ram_addr_o); end
    n_cmp++; if (ram_wdata_o !== 8'h00) begin n_err++; $display("FAIL rst_ram_wdata got %h exp 00", ram_wdata_o); end
    n_cmp++; if (wr_count_o !== 8'd0) begin n_err++; $display("FAIL rst_wr_count got %0d exp 0", wr_count_o); end
    n_cmp++; if (rd_count_o !== 8'd0) begin n_err++; $display("FAIL rst_rd_count got %0d exp 0", rd_count_o); end
    ram_clr = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b exp 1", cmd_ready_o); end
  endtask

  task automatic test_reset_in_resp;
    do_cmd(1'b0, 2'd0, 8'h00);
    tick(); tick();
    n_cmp++; if (rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL rir_valid_before got %b exp 1", rsp_valid_o); end
    n_cmp++; if (rsp_data_o !== 8'h5A) begin n_err++; $display("FAIL rir_data_before got %h exp 5a", rsp_data_o); end
    rsp_ready = 1'b1; rst_n = 1'b0;
    tick();
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL rir_valid got %b exp 0", rsp_valid_o); end
    n_cmp++; if (rsp_data_o !== 8'h00) begin n_err++; $display("FAIL rir_data got %h exp 00", rsp_data_o); end
    n_cmp++; if (rd_count_o !== 8'd0) begin n_err++; $display("FAIL rir_rd_count got %0d exp 0", rd_count_o); end
    rsp_ready = 1'b0; rst_n = 1'b1;
    tick();
    n_cmp++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL rir_idle_ready got %b exp 1", cmd_ready_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL rir_idle_valid got %b exp 0", rsp_valid_o); end
  endtask

  task automatic test_write_read;
    do_cmd(1'b1, 2'd2, 8'hA5);
    n_cmp++; if (ram_we_o !== 1'b1) begin n_err++; $display("FAIL wr_ram_we got %b exp 1", ram_we_o); end
    n_cmp++; if (ram_addr_o !== 2'd2) begin n_err++; $display("FAIL wr_ram_addr got %0d exp 2", ram_addr_o); end
    n_cmp++; if (ram_wdata_o !== 8'hA5) begin n_err++; $display("FAIL wr_ram_wdata got %h exp a5", ram_wdata_o); end
    n_cmp++; if (cmd_ready_o !== 1'b0) begin n_err++; $display("FAIL wr_busy_ready got %b exp 0", cmd_ready_o); end
    tick();
    n_cmp++; if (ram_we_o !== 1'b0) begin n_err++; $display("FAIL wr_we_drop got %b exp 0", ram_we_o); end
    n_cmp++; if (wr_count_o !== 8'd1) begin n_err++; $display("FAIL wr_count got %0d exp 1", wr_count_o); end
    n_cmp++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL wr_idle_ready got %b exp 1", cmd_ready_o); end
    n_cmp++; if (ram_addr_o !== 2'd2) begin n_err++; $display("FAIL wr_addr_hold got %0d exp 2", ram_addr_o); end
    do_cmd(1'b0, 2'd2, 8'h00);
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_valid_c1 got %b exp 0", rsp_valid_o); end
    n_cmp++; if (ram_we_o !== 1'b0) begin n_err++; $display("FAIL rd_ram_we got %b exp 0", ram_we_o); end
    tick();
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_valid_c2 got %b exp 0", rsp_valid_o); end
    tick();
    n_cmp++; if (rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL rd_valid_c3 got %b exp 1", rsp_valid_o); end
    n_cmp++; if (rsp_data_o !== 8'hA5) begin n_err++; $display("FAIL rd_data got %h exp a5", rsp_data_o); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_valid_after got %b exp 0", rsp_valid_o); end
    n_cmp++; if (rd_count_o !== 8'd1) begin n_err++; $display("FAIL rd_count got %0d exp 1", rd_count_o); end
    n_cmp++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL rd_idle_ready got %b exp 1", cmd_ready_o); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_d [4];
    logic [7:0] d;
    int acc [4];
    int idx = 0, cyc = 0, we_cnt = 0;
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    cmd_valid = 1'b1; cmd_write = 1'b1;
    while (idx < 4 && cyc < 40) begin
      cmd_addr = 2'(idx); cmd_wdata = exp_d[idx];
      if (cmd_ready_o) begin acc[idx] = cyc; idx++; end
      tick();
      cyc++;
      we_cnt += int'(ram_we_o);
    end
    cmd_valid = 1'b0;
    tick();
    we_cnt += int'(ram_we_o);
    n_cmp++; if (idx !== 4) begin n_err++; $display("FAIL b2b_accepted got %0d exp 4", idx); end
    for (int i = 1; i < 4; i++) begin
      n_cmp++; if (acc[i] - acc[i-1] !== 2) begin n_err++; $display("FAIL b2b_gap%0d got %0d exp 2", i, acc[i] - acc[i-1]); end
    end
    n_cmp++; if (we_cnt !== 4) begin n_err++; $display("FAIL b2b_we_cycles got %0d exp 4", we_cnt); end
    n_cmp++; if (wr_count_o !== 8'd5) begin n_err++; $display("FAIL b2b_wr_count got %0d exp 5", wr_count_o); end
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b0, 2'(i), 8'h00);
      get_rsp(d);
      n_cmp++; if (d !== exp_d[i]) begin n_err++; $display("FAIL b2b_read%0d got %h exp %h", i, d, exp_d[i]); end
    end
    n_cmp++; if (rd_count_o !== 8'd5) begin n_err++; $display("FAIL b2b_rd_count got %0d exp 5", rd_count_o); end
  endtask

  task automatic test_rsp_stall;
    do_cmd(1'b0, 2'd1, 8'h00);
    tick(); tick();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd3; cmd_wdata = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL stall_valid%0d got %b exp 1", i, rsp_valid_o); end
      n_cmp++; if (rsp_data_o !== 8'h22) begin n_err++; $display("FAIL stall_data%0d got %h exp 22", i, rsp_data_o); end
      n_cmp++; if (cmd_ready_o !== 1'b0) begin n_err++; $display("FAIL stall_ready%0d got %b exp 0", i, cmd_ready_o); end
      tick();
    end
    n_cmp++; if (ram_we_o !== 1'b0) begin n_err++; $display("FAIL stall_ram_we got %b exp 0", ram_we_o); end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL stall_done_valid got %b exp 0", rsp_valid_o); end
    n_cmp++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL stall_done_ready got %b exp 1", cmd_ready_o); end
    n_cmp++; if (rd_count_o !== 8'd6) begin n_err++; $display("FAIL stall_rd_count got %0d exp 6", rd_count_o); end
    n_cmp++; if (wr_count_o !== 8'd5) begin n_err++; $display("FAIL stall_wr_count got %0d exp 5", wr_count_o); end
  endtask

  task automatic test_random;
    logic [7:0] q [$];
    logic [7:0] e;
    int nw = 0, nr = 0, got = 0;
    shadow = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int c = 0; c < 215; c++) begin
      cmd_valid = (c < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = 2'($urandom_range(0, 3));
      cmd_wdata = 8'($urandom);
      rsp_ready = (c < 200) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cmd_valid && cmd_ready_o) begin
        if (cmd_write) begin shadow[cmd_addr] = cmd_wdata; nw++; end
        else begin q.push_back(shadow[cmd_addr]); nr++; end
      end
      if (rsp_valid_o && rsp_ready) begin
        got++;
        n_cmp++;
        if (q.size() == 0) begin n_err++; $display("FAIL rnd_extra_rsp got data %h exp no response", rsp_data_o); end
        else begin
          e = q.pop_front();
          if (rsp_data_o !== e) begin n_err++; $display("FAIL rnd_data got %h exp %h", rsp_data_o, e); end
        end
      end
      tick();
    end
    rsp_ready = 1'b0;
    n_cmp++; if (got !== nr) begin n_err++; $display("FAIL rnd_rsp_count got %0d exp %0d", got, nr); end
    n_cmp++; if (rd_count_o !== 8'(6 + nr)) begin n_err++; $display("FAIL rnd_rd_count got %0d exp %0d", rd_count_o, 6 + nr); end
    n_cmp++; if (wr_count_o !== 8'(5 + nw)) begin n_err++; $display("FAIL rnd_wr_count got %0d exp %0d", wr_count_o, 5 + nw); end
    exp_wr = 5 + nw;
    exp_rd = 6 + nr;
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 300; i++) begin
      do_cmd(1'b1, 2'(i), 8'(i));
      tick();
      exp_wr = (exp_wr < 255) ? exp_wr + 1 : 255;
      if (exp_wr == 200 && i < 299) begin
        n_cmp++; if (wr_count_o !== 8'd200) begin n_err++; $display("FAIL sat_mid got %0d exp 200", wr_count_o); end
        exp_wr = 201;
        do_cmd(1'b1, 2'd0, 8'h00);
        tick();
      end
    end
    n_cmp++; if (wr_count_o !== 8'd255) begin n_err++; $display("FAIL sat_wr_count got %0d exp 255", wr_count_o); end
    n_cmp++; if (rd_count_o !== 8'(exp_rd)) begin n_err++; $display("FAIL sat_rd_count got %0d exp %0d", rd_count_o, exp_rd); end
  endtask

  initial begin
    tick();
    test_reset();
    test_reset_in_resp();
    test_write_read();
    test_back_to_back();
    test_rsp_stall();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
